// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// rtl/imuldiv_muldiv_dispatch_pkg.sv - shared imuldiv message definitions: function codes, tags, helpers
// Purpose: function-code and tag encodings shared by the dispatcher and the mul/div units.
// Ports: none (package).
package imuldiv_muldiv_dispatch_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    // Response-routing tag kept per outstanding request.
    typedef enum logic [1:0] {
        MUL_T  = 2'd0,
        QUO_T  = 2'd1,
        REM_T  = 2'd2,
        ZERO_T = 2'd3
    } tag_t;

    function automatic tag_t fn_to_tag(input logic [2:0] fn);
        tag_t t;
        case (fn)
            FN_MUL:          t = MUL_T;
            FN_DIV, FN_DIVU: t = QUO_T;
            FN_REM, FN_REMU: t = REM_T;
            default:         t = ZERO_T;
        endcase
        return t;
    endfunction

    function automatic logic fn_is_signed(input logic [2:0] fn);
        return (fn == FN_DIV) || (fn == FN_REM);
    endfunction

endpackage

// File: rtl/imuldiv_TagQueue.sv
// rtl/imuldiv_TagQueue.sv - in-order FIFO of response-routing tags
// Purpose: remembers which unit (or none) owes the next response, in request order.
// Ports: clk, reset (async active-low); push/push_tag write; pop retires head;
//        full/empty status; head is the oldest tag (valid only when !empty).
import imuldiv_muldiv_dispatch_pkg::*;

module imuldiv_TagQueue #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output tag_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   FULL_COUNT = DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE    = 1;
    localparam logic [PW-1:0] PTR_ONE    = 1;

    tag_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Local guards keep the queue consistent even if a caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Contents are don't-care after reset; only the pointers/count matter.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// rtl/imuldiv_muldiv_dispatch.sv - routes mul/div requests to units and returns results in order
// Purpose: zero-latency request dispatch to a multiplier or divider, with an in-order
//          tag queue that picks the response source and formats the 64-bit result.
// Ports: clk, reset (async active-low);
//        muldivreq_* upstream request (fn, a, b, val/rdy);
//        mulreq_* / divreq_* requests to the units; mulresp_* / divresp_* unit responses;
//        muldivresp_* downstream response (64-bit result, val/rdy).
import imuldiv_muldiv_dispatch_pkg::*;

module imuldiv_muldiv_dispatch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [2:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,

    output logic        divreq_msg_signed,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,

    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy,

    output logic [63:0] muldivresp_msg_result,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy
);

    tag_t req_tag;
    tag_t head;
    logic full;
    logic empty;
    logic not_full;
    logic unit_rdy;
    logic push;
    logic pop;

    assign req_tag  = fn_to_tag(muldivreq_msg_fn);
    assign not_full = ~full;

    assign mulreq_msg_a      = muldivreq_msg_a;
    assign mulreq_msg_b      = muldivreq_msg_b;
    assign divreq_msg_a      = muldivreq_msg_a;
    assign divreq_msg_b      = muldivreq_msg_b;
    assign divreq_msg_signed = fn_is_signed(muldivreq_msg_fn);

    assign mulreq_val = muldivreq_val & not_full & (req_tag == MUL_T);
    assign divreq_val = muldivreq_val & not_full & ((req_tag == QUO_T) | (req_tag == REM_T));

    // Illegal functions need no unit, so only queue space gates them.
    always_comb begin
        unit_rdy = 1'b1;
        case (req_tag)
            MUL_T:        unit_rdy = mulreq_rdy;
            QUO_T, REM_T: unit_rdy = divreq_rdy;
            default:      unit_rdy = 1'b1;
        endcase
    end

    assign muldivreq_rdy = not_full & unit_rdy;
    assign push          = muldivreq_val & muldivreq_rdy;

    // Only the unit owning the head tag may hand over its response; the other is stalled.
    always_comb begin
        muldivresp_val        = 1'b0;
        muldivresp_msg_result = 64'b0;
        mulresp_rdy           = 1'b0;
        divresp_rdy           = 1'b0;
        if (!empty) begin
            case (head)
                MUL_T: begin
                    muldivresp_val        = mulresp_val;
                    muldivresp_msg_result = mulresp_msg_result;
                    mulresp_rdy           = muldivresp_rdy;
                end
                QUO_T: begin
                    muldivresp_val        = divresp_val;
                    muldivresp_msg_result = {32'b0, divresp_msg_result[31:0]};
                    divresp_rdy           = muldivresp_rdy;
                end
                REM_T: begin
                    muldivresp_val        = divresp_val;
                    muldivresp_msg_result = {32'b0, divresp_msg_result[63:32]};
                    divresp_rdy           = muldivresp_rdy;
                end
                default: begin
                    muldivresp_val        = 1'b1;
                    muldivresp_msg_result = 64'b0;
                end
            endcase
        end
    end

    assign pop = muldivresp_val & muldivresp_rdy;

    imuldiv_TagQueue #(
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_tag (req_tag),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// tb/tb_imuldiv_muldiv_dispatch.sv - scoreboard bench for imuldiv_muldiv_dispatch
module tb_imuldiv_muldiv_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  muldivreq_msg_fn = 3'd0;
    logic [31:0] muldivreq_msg_a = '0;
    logic [31:0] muldivreq_msg_b = '0;
    logic        muldivreq_val = 1'b0;
    logic        muldivreq_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val;
    logic        mulreq_rdy = 1'b1;
    logic        divreq_msg_signed;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy = 1'b1;
    logic [63:0] mulresp_msg_result = '0;
    logic        mulresp_val = 1'b0;
    logic        mulresp_rdy;
    logic [63:0] divresp_msg_result = '0;
    logic        divresp_val = 1'b0;
    logic        divresp_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy = 1'b1;

    imuldiv_muldiv_dispatch #(.DEPTH(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .mulreq_msg_a          (mulreq_msg_a),
        .mulreq_msg_b          (mulreq_msg_b),
        .mulreq_val            (mulreq_val),
        .mulreq_rdy            (mulreq_rdy),
        .divreq_msg_signed     (divreq_msg_signed),
        .divreq_msg_a          (divreq_msg_a),
        .divreq_msg_b          (divreq_msg_b),
        .divreq_val            (divreq_val),
        .divreq_rdy            (divreq_rdy),
        .mulresp_msg_result    (mulresp_msg_result),
        .mulresp_val           (mulresp_val),
        .mulresp_rdy           (mulresp_rdy),
        .divresp_msg_result    (divresp_msg_result),
        .divresp_val           (divresp_val),
        .divresp_rdy           (divresp_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          resp_cnt = 0;
    int          pushed_cnt = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mul_q [$];
    logic [63:0] div_q [$];
    logic [63:0] req_unit_resp = '0;
    logic        mul_en = 1'b1;
    logic        div_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Unit models: each fired request queues the response the bench chose for it.
    always @(posedge clk) begin
        logic mf, mp, df, dp;
        mf = mulreq_val && mulreq_rdy;
        mp = mulresp_val && mulresp_rdy;
        df = divreq_val && divreq_rdy;
        dp = divresp_val && divresp_rdy;
        if (mp) void'(mul_q.pop_front());
        if (mf) mul_q.push_back(req_unit_resp);
        if (dp) void'(div_q.pop_front());
        if (df) div_q.push_back(req_unit_resp);
        #2;
        mulresp_val        = mul_en && (mul_q.size() > 0);
        mulresp_msg_result = (mul_q.size() > 0) ? mul_q[0] : 64'd0;
        divresp_val        = div_en && (div_q.size() > 0);
        divresp_msg_result = (div_q.size() > 0) ? div_q[0] : 64'd0;
    end

    // Monitor: every delivered response is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset && muldivresp_val && muldivresp_rdy) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL resp_unexpected actual=%h required=none", muldivresp_msg_result);
            end else begin
                check("resp", muldivresp_msg_result, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] uresp, input logic [63:0] exp_res, input logic push_exp,
                         input logic exp_mv, input logic exp_dv, input logic exp_sg,
                         output logic resp_val_at_fire);
        logic got;
        muldivreq_msg_fn = fn;
        muldivreq_msg_a  = a;
        muldivreq_msg_b  = b;
        req_unit_resp    = uresp;
        muldivreq_val    = 1'b1;
        if (push_exp) begin
            exp_q.push_back(exp_res);
            pushed_cnt++;
        end
        got = 1'b0;
        resp_val_at_fire = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (muldivreq_rdy) got = 1'b1;
            else @(posedge clk);
        end
        if (!got) begin
            check("issue_timeout", 64'd0, 64'd1);
        end else begin
            check("mulreq_val", {63'd0, mulreq_val}, {63'd0, exp_mv});
            check("divreq_val", {63'd0, divreq_val}, {63'd0, exp_dv});
            check("div_signed", {63'd0, divreq_msg_signed}, {63'd0, exp_sg});
            check("mul_ab", {mulreq_msg_a, mulreq_msg_b}, {a, b});
            check("div_ab", {divreq_msg_a, divreq_msg_b}, {a, b});
            resp_val_at_fire = muldivresp_val;
        end
        @(posedge clk);
        #1;
        muldivreq_val = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic rv;
        // Reset state
        @(negedge clk);
        check("rst_resp_val", {63'd0, muldivresp_val}, 64'd0);
        check("rst_mulresp_rdy", {63'd0, mulresp_rdy}, 64'd0);
        check("rst_divresp_rdy", {63'd0, divresp_rdy}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("idle_req_rdy", {63'd0, muldivreq_rdy}, 64'd1);
        @(posedge clk);
        #1;

        // Signed multiply with negative operand
        issue(3'd0, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 64'hFFFFFFFFFFFFFFEB, 1'b1, 1'b1, 1'b0, 1'b0, rv);
        drain();
        check("one_resp", 64'(resp_cnt), 64'd1);

        // Quotient and remainder extraction, signed and unsigned
        issue(3'd1, 32'd20, 32'd6, 64'h0000000200000003, 64'h3, 1'b1, 1'b0, 1'b1, 1'b1, rv);
        issue(3'd3, 32'd20, 32'd6, 64'h0000000200000003, 64'h2, 1'b1, 1'b0, 1'b1, 1'b1, rv);
        issue(3'd2, 32'd20, 32'd6, 64'h0000000200000003, 64'h3, 1'b1, 1'b0, 1'b1, 1'b0, rv);
        issue(3'd4, 32'd20, 32'd6, 64'h0000000200000003, 64'h2, 1'b1, 1'b0, 1'b1, 1'b0, rv);
        drain();

        // Ordering: mul answers first but must wait behind the outstanding divide
        div_en = 1'b0;
        issue(3'd2, 32'd100, 32'd7, {32'd2, 32'd14}, 64'd14, 1'b1, 1'b0, 1'b1, 1'b0, rv);
        issue(3'd0, 32'd6, 32'd7, 64'd42, 64'd42, 1'b1, 1'b1, 1'b0, 1'b0, rv);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_mulresp_val", {63'd0, mulresp_val}, 64'd1);
        check("stall_mulresp_rdy", {63'd0, mulresp_rdy}, 64'd0);
        check("stall_resp_val", {63'd0, muldivresp_val}, 64'd0);
        @(posedge clk);
        #1 div_en = 1'b1;
        drain();

        // Full queue: fifth request blocked until a pop, including the pop cycle itself
        mul_en = 1'b0;
        for (int k = 1; k <= 4; k++)
            issue(3'd0, 32'(k), 32'd1, 64'(k), 64'(k), 1'b1, 1'b1, 1'b0, 1'b0, rv);
        muldivreq_msg_fn = 3'd0;
        muldivreq_msg_a  = 32'd5;
        muldivreq_msg_b  = 32'd1;
        req_unit_resp    = 64'd5;
        muldivreq_val    = 1'b1;
        exp_q.push_back(64'd5);
        pushed_cnt++;
        @(negedge clk);
        check("full_req_rdy", {63'd0, muldivreq_rdy}, 64'd0);
        check("full_mulreq_val", {63'd0, mulreq_val}, 64'd0);
        @(posedge clk);
        #1 mul_en = 1'b1;
        @(negedge clk);
        check("full_pop_resp_val", {63'd0, muldivresp_val}, 64'd1);
        check("full_pop_req_rdy", {63'd0, muldivreq_rdy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("after_pop_req_rdy", {63'd0, muldivreq_rdy}, 64'd1);
        @(posedge clk);
        #1 muldivreq_val = 1'b0;
        drain();

        // Illegal function: no unit request, zero result the cycle after the push
        issue(3'd7, 32'd5, 32'd9, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, rv);
        check("zero_same_cycle", {63'd0, rv}, 64'd0);
        @(negedge clk);
        check("zero_next_cycle", {63'd0, muldivresp_val}, 64'd1);
        drain();

        // Mid-cycle reset discards outstanding entries
        muldivresp_rdy = 1'b0;
        issue(3'd7, 32'd1, 32'd1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, rv);
        issue(3'd6, 32'd1, 32'd1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, rv);
        @(negedge clk);
        check("pre_reset_resp_val", {63'd0, muldivresp_val}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_resp_val", {63'd0, muldivresp_val}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        muldivresp_rdy = 1'b1;
        @(negedge clk);
        check("post_reset_empty", {63'd0, muldivresp_val}, 64'd0);
        @(posedge clk);
        #1;
        issue(3'd0, 32'd3, 32'd4, 64'd12, 64'd12, 1'b1, 1'b1, 1'b0, 1'b0, rv);
        drain();

        check("resp_total", 64'(resp_cnt), 64'(pushed_cnt));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
